// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Latency: n/a (declarations only). Backpressure: n/a.
// The nibble width is fixed at 4 bits. The lookahead slice depends on that width.
package nibble_serial_sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_sub_4bit_bla_sub.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - br_in.
// Latency: 0 cycles (pure combinational). Backpressure: none; it has no handshake.
// Every borrow is written in flattened sum-of-products form, so the slice has no ripple chain.
module nibble_serial_sub_4bit_bla_sub
    import nibble_serial_sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             br_in,
    output logic [NIB_W-1:0] d,
    output logic             br_out
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   br;

    // A bit generates a borrow when a=0 and b=1. It propagates an incoming borrow when a==b.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign br[0] = br_in;
    assign br[1] = g[0] | (p[0] & br_in);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & br_in);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & br_in);

    assign d      = a ^ b ^ br[NIB_W-1:0];
    assign br_out = br[NIB_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor D = A - B - b_in, LSB nibble first. Optional zero/ovf flags under NIBBLE_SERIAL_SUB_FLAGS_EN.
// Latency: out_valid rises NIB edges after acceptance. Throughput is one op per NIB+2 cycles.
// Backpressure: the result is held in DONE until out_ready. in_ready is high only in IDLE.
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef NIBBLE_SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] d,
    output logic             b_out
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_sub: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] slice_d;
    logic             slice_br;
    logic [WIDTH-1:0] d_next;

    assign in_ready = (state == IDLE);

    // Select the current nibble and merge the slice result into d. Only one slice is shared across all nibbles.
    always_comb begin
        a_nib  = '0;
        b_nib  = '0;
        d_next = d;
        for (int k = 0; k < NIB; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_nib                     = a_q[k*NIB_W +: NIB_W];
                b_nib                     = b_q[k*NIB_W +: NIB_W];
                d_next[k*NIB_W +: NIB_W]  = slice_d;
            end
        end
    end

    nibble_serial_sub_4bit_bla_sub u_slice (
        .a      (a_nib),
        .b      (b_nib),
        .br_in  (borrow),
        .d      (slice_d),
        .br_out (slice_br)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            d         <= '0;
            b_out     <= 1'b0;
            cnt       <= '0;
            borrow    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef NIBBLE_SERIAL_SUB_FLAGS_EN
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= b_in;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    d      <= d_next;
                    borrow <= slice_br;
                    if (cnt == CNT_W'(NIB - 1)) begin
                        b_out     <= slice_br;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
`ifdef NIBBLE_SERIAL_SUB_FLAGS_EN
                        zero      <= (d_next == '0);
                        ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d_next[WIDTH-1]);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: vector table, hold/reset sequences, and random back-to-back ops.
// Define NIBBLE_SERIAL_SUB_FLAGS_EN to also check the zero/ovf outputs.
module tb_nibble_serial_sub;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         b_out;
    logic         zero;
    logic         ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef NIBBLE_SERIAL_SUB_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .d         (d),
        .b_out     (b_out)
    );

`ifndef NIBBLE_SERIAL_SUB_FLAGS_EN
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        exp_t         ex;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        logic [W:0] r;
        exp_t e;
        r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.d    = r[W-1:0];
        e.bout = r[W];
        e.zero = (r[W-1:0] == '0);
        e.ovf  = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ r[W-1]);
        return e;
    endfunction

    task automatic check_result(input string nm);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_d"}, {16'd0, d}, {16'd0, e.d});
            chk({nm, "_b_out"}, {31'd0, b_out}, {31'd0, e.bout});
`ifdef NIBBLE_SERIAL_SUB_FLAGS_EN
            chk({nm, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
            chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
`endif
        end
    endtask

    // Issue one op at (posedge+1). Check its latency and result, and finish with the output handshake done.
    task automatic do_op(input string nm, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic obin, input exp_t ex, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk({nm, "_in_ready_timeout"}, 32'd0, 32'd1);
        a = oa; b = ob; b_in = obin; in_valid = 1'b1;
        sb_q.push_back(ex);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, NIB);
        check_result(nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int first_acc;
        int last_acc;
        int n;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rbin;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{16'h8000, 16'h0000, 1'b1, '{16'h7FFF, 1'b0, 1'b0, 1'b1}};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{16'h5A5A, 16'h5A5A, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b0, '{16'hFFFF, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b1}};
        vecs[7] = '{16'h0001, 16'h0001, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", {16'd0, d}, 32'd0);
        chk("rst_b_out", {31'd0, b_out}, 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ex, acc);
        end

        // Hold the result in DONE for 10 cycles. A competing request arrives meanwhile and must be ignored.
        out_ready = 1'b0;
        a = 16'h00FF; b = 16'h00FF; b_in = 1'b0; in_valid = 1'b1;
        sb_q.push_back(model(16'h00FF, 16'h00FF, 1'b0));
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h0001; b_in = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency", n, NIB);
        for (int i = 0; i < 10; i++) begin
            chk("hold_d", {16'd0, d}, 32'd0);
            chk("hold_b_out", {31'd0, b_out}, 32'd0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef NIBBLE_SERIAL_SUB_FLAGS_EN
            chk("hold_zero", {31'd0, zero}, 32'd1);
`endif
            if (i == 9) in_valid = 1'b0;
            else begin @(posedge clk); #1; end
        end
        check_result("hold");
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Apply reset in the second RUN cycle. The partial result must be dropped at once.
        a = 16'hAAAA; b = 16'h5555; b_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_rst_d", {16'd0, d}, 32'd0);
        chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_rst", 16'h0005, 16'h0003, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0}, acc);

        // Random back-to-back ops with out_ready held high.
        first_acc = 0;
        last_acc  = 0;
        for (int i = 0; i < 100; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(1, 0));
            e    = model(ra, rb, rbin);
            do_op($sformatf("rnd%0d", i), ra, rb, rbin, e, acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
        end
        chk("rnd_throughput", last_acc - first_acc, 99 * (NIB + 2));
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
